// File: rtl/mem_access_unit.sv
// Load/store initiator: turns byte/half/word CPU requests into aligned word accesses,
// using read-modify-write for sub-word stores and lane extraction for sub-word loads.
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [31:0] LIMIT_WORD = 32'(MEM_BYTES - 4);
    localparam logic [31:0] LIMIT_HALF = 32'(MEM_BYTES - 2);
    localparam logic [31:0] LIMIT_BYTE = 32'(MEM_BYTES);

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] word_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;

    logic        req_err;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Alignment and range check on the incoming request; only used at accept.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = (req_addr >= LIMIT_BYTE);
            2'b01:   req_err = req_addr[0] || (req_addr > LIMIT_HALF);
            2'b10:   req_err = (|req_addr[1:0]) || (req_addr > LIMIT_WORD);
            default: req_err = 1'b1;
        endcase
    end

    // Load lane extraction and extension, from the live memory word during RD.
    assign rd_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
    assign rd_byte    = rd_shifted[7:0];
    assign rd_half    = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_value = mem_rdata;
        case (size_reg)
            2'b00:   load_value = {{24{~unsigned_reg & rd_byte[7]}}, rd_byte};
            2'b01:   load_value = {{16{~unsigned_reg & rd_half[15]}}, rd_half};
            default: load_value = mem_rdata;
        endcase
    end

    // Sub-word store merge: each lane takes new data only if it is the target lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] =
                (size_reg == 2'b00 && addr_reg[1:0] == 2'(gi)) ? wdata_reg[7:0] :
                (size_reg == 2'b01 && addr_reg[1] == 1'(gi / 2)) ? wdata_reg[8*(gi%2) +: 8] :
                word_reg[8*gi +: 8];
        end
    endgenerate

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign mem_rd     = (state_reg == RD);
    assign mem_wr     = (state_reg == WR);
    assign mem_addr   = {addr_reg[31:2], 2'b00};
    assign mem_wdata  = (state_reg != WR) ? 32'd0 :
                        (size_reg == 2'b10) ? wdata_reg : merged_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            word_reg       <= 32'd0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg       <= req_we;
                        size_reg     <= req_size;
                        unsigned_reg <= req_unsigned;
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        if (req_err) begin
                            resp_err_reg <= 1'b1;
                            state_reg    <= RESP;
                        end else if (!req_we || req_size != 2'b10) begin
                            state_reg <= RD;
                        end else begin
                            state_reg <= WR;
                        end
                    end
                end
                RD: begin
                    word_reg <= mem_rdata;
                    if (we_reg) begin
                        state_reg <= WR;
                    end else begin
                        resp_rdata_reg <= load_value;
                        state_reg      <= RESP;
                    end
                end
                WR: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'd0;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide memory model on the memory port.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        mem_clr;
    logic [31:0] last_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (mem_wr) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_lat, input int exp_rd, input int exp_wr);
        int  n;
        int  lat;
        int  rd_n;
        int  wr_n;
        bit  got;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd_n = 0; wr_n = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_rd) rd_n++;
            if (mem_wr) begin
                wr_n++;
                last_wdata = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1;
                chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
                chk({tag, " rdata"}, resp_rdata, exp_rdata);
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rd_strobes"}, 32'(rd_n), 32'(exp_rd));
        chk({tag, " wr_strobes"}, 32'(wr_n), 32'(exp_wr));
        $display("req %s we=%0b size=%0d addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d",
                 tag, we, size, addr, wdata, resp_err, resp_rdata, lat);
    endtask

    initial begin
        int  n;
        int  k;
        int  wr_n;
        int  rv_n;
        bit  got;

        reset = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; last_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset mem_rd", 32'(mem_rd), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // Word store then load
        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1);
        chk("sw10 mem", mem[4], 32'hDEADBEEF);
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1, 0);

        // Byte store and loads
        do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h5A, 1'b0, 32'h0, 3, 1, 1);
        chk("sb11 wdata", last_wdata, 32'hDEAD5AEF);
        chk("sb11 mem", mem[4], 32'hDEAD5AEF);
        do_req("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000005A, 2, 1, 0);
        do_req("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1, 0);
        do_req("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000DE, 2, 1, 0);

        // Halfword store and loads
        do_req("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001, 1'b0, 32'h0, 3, 1, 1);
        chk("sh12 mem", mem[4], 32'h80015AEF);
        do_req("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF8001, 2, 1, 0);
        do_req("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00008001, 2, 1, 0);
        do_req("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00005AEF, 2, 1, 0);

        // Error requests and range boundaries
        do_req("lw12_err", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0, 1, 0, 0);
        do_req("lh13_err", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1, 0, 0);
        do_req("sw400_err", 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 1'b1, 32'h0, 1, 0, 0);
        do_req("size3_err", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
        do_req("sb400_err", 1'b1, 2'b00, 1'b0, 32'h400, 32'h11, 1'b1, 32'h0, 1, 0, 0);
        do_req("lh400_err", 1'b0, 2'b01, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1, 0, 0);
        do_req("sw3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA1B2C3D4, 1'b0, 32'h0, 2, 0, 1);
        do_req("lb3ff", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 1'b0, 32'h000000A1, 2, 1, 0);
        do_req("lh3fe", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, 1'b0, 32'hFFFFA1B2, 2, 1, 0);
        chk("err mem unchanged", mem[4], 32'h80015AEF);

        // Reset asserted while the sub-word store is in its read phase
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid in RD", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        wr_n = 0; rv_n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (mem_wr) wr_n++;
            if (resp_valid) rv_n++;
            @(negedge clk);
        end
        reset = 1'b0;
        chk("rst_mid ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wr) wr_n++;
            if (resp_valid) rv_n++;
        end
        chk("rst_mid wr_strobes", 32'(wr_n), 32'd0);
        chk("rst_mid resp_pulses", 32'(rv_n), 32'd0);
        chk("rst_mid mem", mem[4], 32'h80015AEF);
        $display("req rst_mid sb addr=00000010 aborted wr=%0d resp=%0d", wr_n, rv_n);

        // Back-to-back with req_valid held high
        vecs[0] = '{we: 1'b1, size: 2'b10, uns: 1'b0, addr: 32'h20, wdata: 32'h11223344, rdata: 32'h0};
        vecs[1] = '{we: 1'b0, size: 2'b00, uns: 1'b0, addr: 32'h21, wdata: 32'h0, rdata: 32'h00000033};
        vecs[2] = '{we: 1'b1, size: 2'b01, uns: 1'b0, addr: 32'h22, wdata: 32'hABCD, rdata: 32'h0};
        vecs[3] = '{we: 1'b0, size: 2'b01, uns: 1'b1, addr: 32'h22, wdata: 32'h0, rdata: 32'h0000ABCD};
        @(negedge clk);
        req_we = vecs[0].we; req_size = vecs[0].size; req_unsigned = vecs[0].uns;
        req_addr = vecs[0].addr; req_wdata = vecs[0].wdata; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            if (i < 3) begin
                req_we = vecs[i+1].we; req_size = vecs[i+1].size; req_unsigned = vecs[i+1].uns;
                req_addr = vecs[i+1].addr; req_wdata = vecs[i+1].wdata;
            end else begin
                req_valid = 1'b0;
            end
            got = 1'b0; k = 0;
            while (!got && k < 10) begin
                @(negedge clk);
                k++;
                if (resp_valid) got = 1'b1;
                else chk($sformatf("b2b%0d ready_busy", i), 32'(req_ready), 32'd0);
            end
            chk($sformatf("b2b%0d resp", i), 32'(got), 32'd1);
            chk($sformatf("b2b%0d err", i), 32'(resp_err), 32'd0);
            chk($sformatf("b2b%0d rdata", i), resp_rdata, vecs[i].rdata);
            $display("req b2b%0d we=%0b size=%0d addr=%h -> rdata=%h lat=%0d",
                     i, vecs[i].we, vecs[i].size, vecs[i].addr, resp_rdata, k);
        end
        chk("b2b mem", mem[8], 32'hABCD3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
